tt_um_array_divider_hhrb98: RTL and testbench
=============================================

TT_UM_ARRAY_DIVIDER_HHRB98 -- requirements
Module: tt_um_array_divider_hhrb98

Interface
REQ-001 Parameters: none; block is fixed 8-bit dividend / 4-bit divisor.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 ena  input  1  high = design enabled; low = all state held.
REQ-005 ui_in  input  8  dividend.
REQ-006 uio_in  input  8  [3:0] divisor, [4] start, [5] result select (see REQ-030..031), [7:6] unused.
REQ-007 uo_out  output  8  registered quotient (or remainder, see Configuration).
REQ-008 uio_out  output  8  [7] div_by_zero, [6] done, [5] busy, [4:0] = 0.
REQ-009 uio_oe  output  8  constant 8'b1110_0000.

Function
REQ-010 Sequential restoring divider: Q = floor(ui_in / divisor), R = ui_in mod divisor; R always < 16, 4 bits.
REQ-011 FSM states IDLE, RUN, DONE; busy = (state==RUN), done = (state==DONE).
REQ-012 IDLE: on edge with ena=1 and start=1, capture dividend and divisor into internal registers; divisor != 0 -> RUN with step count 0; divisor == 0 -> DONE.
REQ-013 RUN: each enabled edge performs one restoring step (shift in next dividend bit MSB-first, trial subtract using 5-bit partial remainder, set quotient bit); after step 7 -> DONE.
REQ-014 Latency: done asserts after 9 enabled edges counted from the capture edge; divide-by-zero: done after 1 edge.
REQ-015 On DONE entry, quotient/remainder/div_by_zero result registers update; they hold until the next DONE entry.
REQ-016 uo_out and div_by_zero show the previous result while RUN is in progress.
REQ-017 Divide by zero: Q = 8'hFF, R = 4'h0, div_by_zero = 1; otherwise div_by_zero = 0.
REQ-018 Four-phase handshake: DONE holds until start = 0 is sampled, then -> IDLE; start held high does not retrigger.
REQ-019 ui_in and divisor changes after the capture edge do not affect the running operation.
REQ-020 ena = 0: FSM, step counter and all registers hold; operation resumes when ena returns to 1.

Reset
REQ-021 rst_n low forces immediately: state IDLE, step count 0, operand registers 0, quotient 0, remainder 0, div_by_zero 0.
REQ-022 Resulting outputs: uo_out = 8'h00, uio_out = 8'h00, uio_oe = 8'hE0.
REQ-023 Reset mid-RUN aborts the operation; no partial result becomes visible.

Configuration
REQ-030 Macro DIV_REMAINDER_READ_EN defined: uio_in[5] = 1 selects uo_out = {4'b0, remainder}; uio_in[5] = 0 selects quotient; the mux is combinational on registered data.
REQ-031 Macro undefined: uo_out = quotient always; uio_in[5] ignored; no remainder register is required.

Verification
REQ-040 ui_in = 200, divisor = 7, start pulse -> busy for 8 cycles, done on 9th edge, uo_out = 28; with macro and select = 1, uo_out = 4.
REQ-041 ui_in = 225, divisor = 15 -> Q = 15, R = 0; ui_in = 255, divisor = 1 -> Q = 255, R = 0, div_by_zero = 0.
REQ-042 ui_in = 50, divisor = 0 -> done after 1 edge, uo_out = 8'hFF, R = 0, div_by_zero = 1, busy never high.
REQ-043 start held high through DONE -> no new operation; drop start -> IDLE next edge; new start with 143/11 -> Q = 13, R = 0.
REQ-044 rst_n low at step 4 of 200/7 -> outputs 0, IDLE; next run 100/9 -> Q = 11, R = 1.
REQ-045 ena low for 3 cycles mid-RUN -> done delayed exactly 3 cycles, result unchanged (200/7 -> 28).

Source files
------------

// File: rtl/tt_um_array_divider_hhrb98.sv
// Sequential restoring divider: 8-bit dividend / 4-bit divisor, one quotient bit per enabled cycle.
// Optional macro DIV_REMAINDER_READ_EN adds a remainder register readable via uio_in[5].
module tt_um_array_divider_hhrb98 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [1:0] state_q;
    logic [2:0] step_q;
    logic [7:0] work_q;     // dividend bits shift out the top, quotient bits shift in the bottom
    logic [3:0] divisor_q;
    logic [3:0] part_q;
    logic [7:0] quot_q;
    logic       dbz_q;

    logic       start;
    logic [3:0] divisor_in;
    assign start      = uio_in[4];
    assign divisor_in = uio_in[3:0];

    // One restoring step; partial remainder stays below the divisor, so 4 bits suffice after it.
    logic [4:0] trial;
    logic [4:0] diff;
    logic       fits;
    logic [3:0] part_nxt;
    logic [7:0] work_nxt;

    always_comb begin
        trial    = {part_q, work_q[7]};
        diff     = trial - {1'b0, divisor_q};
        fits     = trial >= {1'b0, divisor_q};
        part_nxt = fits ? diff[3:0] : trial[3:0];
        work_nxt = {work_q[6:0], fits};
    end

`ifdef DIV_REMAINDER_READ_EN
    logic [3:0] rem_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q <= 4'h0;
        end else if (ena) begin
            if (state_q == StIdle && start) begin
                if (divisor_in == 4'h0) rem_q <= 4'h0;
            end else if (state_q == StRun && step_q == 3'd7) begin
                rem_q <= part_nxt;
            end
        end
    end

    assign uo_out = uio_in[5] ? {4'b0000, rem_q} : quot_q;

    logic unused_in;
    assign unused_in = ^uio_in[7:6];
`else
    assign uo_out = quot_q;

    logic unused_in;
    assign unused_in = ^uio_in[7:5];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            step_q    <= 3'd0;
            work_q    <= 8'h00;
            divisor_q <= 4'h0;
            part_q    <= 4'h0;
            quot_q    <= 8'h00;
            dbz_q     <= 1'b0;
        end else if (ena) begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        work_q    <= ui_in;
                        divisor_q <= divisor_in;
                        part_q    <= 4'h0;
                        step_q    <= 3'd0;
                        if (divisor_in == 4'h0) begin
                            state_q <= StDone;
                            quot_q  <= 8'hFF;
                            dbz_q   <= 1'b1;
                        end else begin
                            state_q <= StRun;
                        end
                    end
                end
                StRun: begin
                    work_q <= work_nxt;
                    part_q <= part_nxt;
                    step_q <= step_q + 3'd1;
                    if (step_q == 3'd7) begin
                        state_q <= StDone;
                        quot_q  <= work_nxt;
                        dbz_q   <= 1'b0;
                    end
                end
                StDone: begin
                    if (!start) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign uio_out = {dbz_q, state_q == StDone, state_q == StRun, 5'b00000};
    assign uio_oe  = 8'hE0;

endmodule

// File: tb/tb_tt_um_array_divider_hhrb98.sv
// Self-checking bench for tt_um_array_divider_hhrb98: directed and random divisions vs arithmetic model.
module tb_tt_um_array_divider_hhrb98;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] last_q = 8'h00;  // model of the result register

    tt_um_array_divider_hhrb98 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full operation a/b with an optional ena-low window starting gap_at edges after capture.
    task automatic run_div(input logic [7:0] a, input logic [3:0] b,
                           input int gap_at, input int gap_len);
        logic [7:0] exp_q;
        logic [3:0] exp_r;
        int         edges;
        int         exp_lat;
        exp_q   = (b == 0) ? 8'hFF : 8'(a / b);
        exp_r   = (b == 0) ? 4'h0 : 4'(a % b);
        exp_lat = (b == 0) ? 1 : 9 + gap_len;
        ui_in   = a;
        uio_in  = {3'b000, 1'b1, b};
        tick();
        edges = 1;
        if (b != 0) begin
            check("busy_after_capture", uio_out[5], 1'b1);
            check("prev_result_held", uo_out, last_q);
        end else begin
            check("dbz_never_busy", uio_out[5], 1'b0);
        end
        // Scramble inputs; the running operation must ignore them.
        ui_in  = 8'($urandom);
        uio_in = {3'b000, 1'b1, 4'($urandom)};
        while (!uio_out[6] && edges < 40) begin
            ena = !(gap_len > 0 && edges >= gap_at && edges < gap_at + gap_len);
            tick();
            edges++;
        end
        ena = 1'b1;
        check("latency", edges, exp_lat);
        check("done", uio_out[6], 1'b1);
        check("quotient", uo_out, exp_q);
        check("div_by_zero", uio_out[7], b == 0);
        check("uio_out_low", uio_out[4:0], 5'b0);
`ifdef DIV_REMAINDER_READ_EN
        uio_in[5] = 1'b1;
        #1;
        check("remainder", uo_out, {4'b0000, exp_r});
        uio_in[5] = 1'b0;
        #1;
`else
        if (exp_r > 4'hF) check("rem_range", exp_r, 4'h0);
`endif
        last_q = exp_q;
        // start held through DONE must not retrigger
        repeat (3) tick();
        check("hold_done", uio_out[6:5], 2'b10);
        uio_in[4] = 1'b0;
        tick();
        check("back_idle", uio_out[6:5], 2'b00);
        check("idle_result", uo_out, exp_q);
    endtask

    initial begin
        #12;
        check("rst_uo_out", uo_out, 8'h00);
        check("rst_uio_out", uio_out, 8'h00);
        check("rst_uio_oe", uio_oe, 8'hE0);
        rst_n = 1'b1;
        tick();

        run_div(8'd200, 4'd7, 0, 0);
        run_div(8'd225, 4'd15, 0, 0);
        run_div(8'd255, 4'd1, 0, 0);
        run_div(8'd50, 4'd0, 0, 0);
        run_div(8'd143, 4'd11, 0, 0);
        run_div(8'd200, 4'd7, 3, 3);

        // Reset during step 4 of 200/7
        ui_in  = 8'd200;
        uio_in = 8'h17;
        repeat (5) tick();
        check("mid_run_busy", uio_out[5], 1'b1);
        rst_n = 1'b0;
        #1;
        check("abort_uo_out", uo_out, 8'h00);
        check("abort_uio_out", uio_out, 8'h00);
        uio_in = 8'h00;
        #2;
        rst_n  = 1'b1;
        last_q = 8'h00;
        tick();
        check("abort_idle", uio_out, 8'h00);
        run_div(8'd100, 4'd9, 0, 0);

        for (int i = 0; i < 24; i++) begin
            logic [7:0] a;
            logic [3:0] b;
            int         gl;
            a  = 8'($urandom);
            b  = (i % 6 == 5) ? 4'h0 : 4'($urandom);
            gl = (i % 4 == 3) ? int'($urandom_range(1, 4)) : 0;
            run_div(a, b, int'($urandom_range(1, 7)), gl);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
